// File: rtl/udp_axis_pkg.sv
// Shared types and helpers for the UDP AXI-stream transmit path.
package udp_axis_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Index width that stays at least one bit even for a two-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/udp_rr_pick.sv
// Rotating-priority encoder: returns the first asserted req at or after ptr, wrapping.
module udp_rr_pick
    import udp_axis_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = clog2_min1(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        j     = 0;
        // Walk the scan order backwards so the candidate nearest ptr is written last and wins.
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N_PORTS;
            if (req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter with max-length truncation onto one AXI-stream egress.
// Optional per-port packet and truncation counters are built when UDP_ARB_STATS_EN is defined.
module udp_tx_arbiter
    import udp_axis_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          s_valid,
    output logic [N_PORTS-1:0]          s_ready,
    input  logic [N_PORTS*DATA_W-1:0]   s_data,
    input  logic [N_PORTS-1:0]          s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_last,
    output logic [clog2_min1(N_PORTS)-1:0] grant_id,
    output logic                        busy,
`ifdef UDP_ARB_STATS_EN
    output logic [N_PORTS*16-1:0]       pkt_cnt,
    output logic [15:0]                 trunc_cnt,
`endif
    output logic                        trunc_pulse
);

    localparam int IDX_W = clog2_min1(N_PORTS);
    localparam int CNT_W = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_WORDS - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             trunc_q, trunc_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  next_ptr;
    logic              g_valid, g_last, at_max, pass_hs;
    logic [DATA_W-1:0] g_data;

    udp_rr_pick #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (s_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_valid  = s_valid[grant_q];
    assign g_last   = s_last[grant_q];
    assign g_data   = s_data[int'(grant_q)*DATA_W +: DATA_W];
    assign at_max   = (beat_cnt_q == LAST_BEAT);
    assign pass_hs  = (state_q == PASS) && g_valid && m_ready;
    assign next_ptr = (grant_q == IDX_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every target and no latch is inferred.
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = PASS;
                end
            end
            PASS: begin
                if (pass_hs) begin
                    // Tops out at MAX_WORDS, which CNT_W holds, so the counter cannot wrap.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (g_last) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (g_valid && g_last) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready = '0;
        m_valid = 1'b0;
        m_data  = g_data;
        m_last  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            PASS: begin
                s_ready[grant_q] = m_ready;
                m_valid          = g_valid;
                m_last           = g_last || at_max;
                busy             = 1'b1;
            end
            DRAIN: begin
                s_ready[grant_q] = 1'b1;
                busy             = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_id    = grant_q;
    assign trunc_pulse = trunc_q;

`ifdef UDP_ARB_STATS_EN
    logic [N_PORTS-1:0][15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]              trunc_cnt_q, trunc_cnt_d;
    logic                     pkt_done;

    // A packet leaves PASS on its last accepted beat, whether by s_last or by the length cap.
    assign pkt_done = pass_hs && (g_last || at_max);

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (pkt_done && (pkt_cnt_q[grant_q] != 16'hFFFF)) begin
            pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 16'd1;
        end
        if (trunc_q && (trunc_cnt_q != 16'hFFFF)) begin
            trunc_cnt_d = trunc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign trunc_cnt = trunc_cnt_q;
`endif

endmodule
